// File: rtl/servio_mem_pkg.sv
// Shared helpers for the servio on-chip memories: address-width rule,
// read-during-write mode constants and byte-lane merge.
package servio_mem_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAX_DW = 1024;
  localparam int MAX_SW = MAX_DW / 8;

  typedef logic [MAX_DW-1:0] mem_word_t;
  typedef logic [MAX_SW-1:0] mem_sel_t;

  typedef struct packed {
    logic in_range;
    logic fwd;
  } rd_ctl_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic mem_word_t byte_merge(input mem_word_t old_w,
                                           input mem_word_t new_w,
                                           input mem_sel_t  sel);
    mem_word_t res;
    res = old_w;
    for (int i = 0; i < MAX_SW; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servio_dpram_rdpipe.sv
// Read pipeline: fixes the read word at acceptance (forwarding and range
// applied there) and delivers rdt/ack after READ_LATENCY cycles.
module servio_dpram_rdpipe
  import servio_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_vld,
  input  rd_ctl_t                 rd_ctl,
  input  logic [DATA_WIDTH-1:0]   raw_word,
  input  logic [DATA_WIDTH-1:0]   wr_dat,
  input  logic [DATA_WIDTH/8-1:0] wr_sel,
  output logic [DATA_WIDTH-1:0]   rdt,
  output logic                    ack
);

  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] cap_word;
  logic [DATA_WIDTH-1:0] out_word;
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] rdt_d, rdt_q;
  logic                  ack_d, ack_q;
  mem_word_t             merge_full;

  always_comb begin
    merge_full  = byte_merge(mem_word_t'(raw_word), mem_word_t'(wr_dat), mem_sel_t'(wr_sel));
    merged_word = merge_full[DATA_WIDTH-1:0];
    cap_word    = '0;
    if (rd_ctl.in_range) cap_word = rd_ctl.fwd ? merged_word : raw_word;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_vld_d, s1_vld_q;
    logic [DATA_WIDTH-1:0] s1_word_d, s1_word_q;

    always_comb begin
      s1_vld_d  = rd_vld;
      s1_word_d = rd_vld ? cap_word : s1_word_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_vld_q  <= 1'b0;
        s1_word_q <= '0;
      end else begin
        s1_vld_q  <= s1_vld_d;
        s1_word_q <= s1_word_d;
      end
    end

    assign out_vld  = s1_vld_q;
    assign out_word = s1_word_q;
  end else begin : g_lat1
    assign out_vld  = rd_vld;
    assign out_word = cap_word;
  end

  // rdt only moves on an ack so the consumer may sample it late.
  always_comb begin
    ack_d = out_vld;
    rdt_d = out_vld ? out_word : rdt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      ack_q <= ack_d;
      rdt_q <= rdt_d;
    end
  end

  assign rdt = rdt_q;
  assign ack = ack_q;

endmodule

// File: rtl/servio_dpram.sv
// Simple dual-port RAM: s0 pipelined read port, s1 byte-lane write port,
// defined read-during-write and out-of-range handling.
module servio_dpram
  import servio_mem_pkg::*;
#(
  parameter int DATA_DEPTH   = 1024,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [addr_width(DATA_DEPTH)-1:0]    wb_s0_adr,
  input  logic                                 wb_s0_cyc,
  output logic [DATA_WIDTH-1:0]                wb_s0_rdt,
  output logic                                 wb_s0_ack,
  input  logic [addr_width(DATA_DEPTH)-1:0]    wb_s1_adr,
  input  logic                                 wb_s1_cyc,
  input  logic                                 wb_s1_we,
  input  logic [DATA_WIDTH/8-1:0]              wb_s1_sel,
  input  logic [DATA_WIDTH-1:0]                wb_s1_dat,
  output logic                                 wb_s1_ack
);

  localparam int AW = addr_width(DATA_DEPTH);
  localparam int SW = DATA_WIDTH / 8;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("servio_dpram: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
    $error("servio_dpram: DATA_WIDTH must be a multiple of 8 and <= MAX_DW");
  end
  if (DATA_DEPTH < 2) begin : g_bad_depth
    $error("servio_dpram: DATA_DEPTH must be >= 2");
  end

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic          rd_in_range, wr_in_range;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          wr_accept, wr_en;
  logic          rd_vld;
  rd_ctl_t       rd_ctl;
  logic [DATA_WIDTH-1:0] raw_word;
  logic          wack_d, wack_q;

  // Non-power-of-two depths leave holes in the address space; those are
  // steered to index 0 and masked so nothing aliases.
  always_comb begin
    rd_in_range = int'(wb_s0_adr) < DATA_DEPTH;
    wr_in_range = int'(wb_s1_adr) < DATA_DEPTH;
    rd_idx      = rd_in_range ? wb_s0_adr : '0;
    wr_idx      = wr_in_range ? wb_s1_adr : '0;
    wr_accept   = wb_s1_cyc & wb_s1_we & ~reset;
    wr_en       = wr_accept & wr_in_range;
    rd_vld      = wb_s0_cyc & ~reset;
    raw_word    = mem[rd_idx];
    rd_ctl.in_range = rd_in_range;
    rd_ctl.fwd      = (RDW_MODE == RDW_NEW) && wr_en && rd_in_range
                      && (wb_s0_adr == wb_s1_adr);
    wack_d      = wr_accept;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < SW; i++) begin
        if (wb_s1_sel[i]) mem[wr_idx][8*i +: 8] <= wb_s1_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wack_q <= 1'b0;
    else       wack_q <= wack_d;
  end

  assign wb_s1_ack = wack_q;

  servio_dpram_rdpipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe (
    .clk      (clk),
    .reset    (reset),
    .rd_vld   (rd_vld),
    .rd_ctl   (rd_ctl),
    .raw_word (raw_word),
    .wr_dat   (wb_s1_dat),
    .wr_sel   (wb_s1_sel),
    .rdt      (wb_s0_rdt),
    .ack      (wb_s0_ack)
  );

endmodule

// File: tb/tb_servio_dpram.sv
// Directed bench for servio_dpram: two instances (latency 1 / old-data RDW
// and latency 2 / new-data RDW, both depth 1000) driven with shared stimulus.
module tb_servio_dpram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  s0_adr = '0;
  logic        s0_cyc = 1'b0;
  logic [9:0]  s1_adr = '0;
  logic        s1_cyc = 1'b0;
  logic        s1_we = 1'b0;
  logic [3:0]  s1_sel = '0;
  logic [31:0] s1_dat = '0;

  logic [31:0] rdt_a, rdt_b;
  logic        ack_a, ack_b, wack_a, wack_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  servio_dpram #(.DATA_DEPTH(1000), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .wb_s0_adr(s0_adr), .wb_s0_cyc(s0_cyc), .wb_s0_rdt(rdt_a), .wb_s0_ack(ack_a),
    .wb_s1_adr(s1_adr), .wb_s1_cyc(s1_cyc), .wb_s1_we(s1_we), .wb_s1_sel(s1_sel),
    .wb_s1_dat(s1_dat), .wb_s1_ack(wack_a)
  );

  servio_dpram #(.DATA_DEPTH(1000), .DATA_WIDTH(32), .READ_LATENCY(2), .RDW_MODE(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .wb_s0_adr(s0_adr), .wb_s0_cyc(s0_cyc), .wb_s0_rdt(rdt_b), .wb_s0_ack(ack_b),
    .wb_s1_adr(s1_adr), .wb_s1_cyc(s1_cyc), .wb_s1_we(s1_we), .wb_s1_sel(s1_sel),
    .wb_s1_dat(s1_dat), .wb_s1_ack(wack_b)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic [9:0]  radr;
    logic        wcyc;
    logic        wwe;
    logic [9:0]  wadr;
    logic [31:0] wdat;
    logic [3:0]  wsel;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic [9:0] radr,
                              input logic wcyc, input logic wwe, input logic [9:0] wadr,
                              input logic [31:0] wdat, input logic [3:0] wsel,
                              input logic [31:0] exp_a, input logic [31:0] exp_b);
    vec_t v;
    v.name = name; v.rd = rd; v.radr = radr; v.wcyc = wcyc; v.wwe = wwe;
    v.wadr = wadr; v.wdat = wdat; v.wsel = wsel; v.exp_a = exp_a; v.exp_b = exp_b;
    return v;
  endfunction

  // One-cycle transaction, then check latency-1 results and latency-2 results.
  task automatic apply_vec(input vec_t v);
    @(posedge clk); #1;
    s0_cyc = v.rd;   s0_adr = v.radr;
    s1_cyc = v.wcyc; s1_we = v.wwe; s1_adr = v.wadr; s1_dat = v.wdat; s1_sel = v.wsel;
    @(posedge clk); #1;
    s0_cyc = 1'b0; s1_cyc = 1'b0; s1_we = 1'b0;
    @(negedge clk);
    chk({v.name, ".wack_a"}, 32'(wack_a), 32'(v.wcyc & v.wwe));
    chk({v.name, ".wack_b"}, 32'(wack_b), 32'(v.wcyc & v.wwe));
    chk({v.name, ".ack_a"},  32'(ack_a),  32'(v.rd));
    chk({v.name, ".ack_b_early"}, 32'(ack_b), 32'(0));
    if (v.rd) chk({v.name, ".rdt_a"}, rdt_a, v.exp_a);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, ".ack_a_late"}, 32'(ack_a), 32'(0));
    chk({v.name, ".wack_a_once"}, 32'(wack_a), 32'(0));
    chk({v.name, ".ack_b"}, 32'(ack_b), 32'(v.rd));
    if (v.rd) chk({v.name, ".rdt_b"}, rdt_b, v.exp_b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk("wr5",       0, 0,    1, 1, 5,    32'hDEADBEEF, 4'hF, 0, 0);
    vecs[1]  = mk("rd5",       1, 5,    0, 0, 0,    0,            4'h0, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[2]  = mk("wr3",       0, 0,    1, 1, 3,    32'h11223344, 4'hF, 0, 0);
    vecs[3]  = mk("wr3_lanes", 0, 0,    1, 1, 3,    32'hAABBCCDD, 4'h5, 0, 0);
    vecs[4]  = mk("rd3",       1, 3,    0, 0, 0,    0,            4'h0, 32'h11BB33DD, 32'h11BB33DD);
    vecs[5]  = mk("wr9",       0, 0,    1, 1, 9,    32'h0,        4'hF, 0, 0);
    vecs[6]  = mk("rdw9",      1, 9,    1, 1, 9,    32'hFFFFFFFF, 4'h3, 32'h00000000, 32'h0000FFFF);
    vecs[7]  = mk("rd9",       1, 9,    0, 0, 0,    0,            4'h0, 32'h0000FFFF, 32'h0000FFFF);
    vecs[8]  = mk("wr10",      0, 0,    1, 1, 10,   32'h12345678, 4'hF, 0, 0);
    vecs[9]  = mk("wr498",     0, 0,    1, 1, 498,  32'h0BADF00D, 4'hF, 0, 0);
    vecs[10] = mk("wr1010",    0, 0,    1, 1, 1010, 32'h00000055, 4'hF, 0, 0);
    vecs[11] = mk("rd1010",    1, 1010, 0, 0, 0,    0,            4'h0, 32'h0, 32'h0);
    vecs[12] = mk("rd10",      1, 10,   0, 0, 0,    0,            4'h0, 32'h12345678, 32'h12345678);
    vecs[13] = mk("rd498",     1, 498,  0, 0, 0,    0,            4'h0, 32'h0BADF00D, 32'h0BADF00D);
    vecs[14] = mk("rdw1010",   1, 1010, 1, 1, 1010, 32'hFFFFFFFF, 4'hF, 32'h0, 32'h0);
    vecs[15] = mk("rd10_wr5",  1, 10,   1, 1, 5,    32'h0,        4'hF, 32'h12345678, 32'h12345678);
    vecs[16] = mk("wr5_sel0",  1, 5,    1, 1, 5,    32'hFFFFFFFF, 4'h0, 32'h0, 32'h0);
    vecs[17] = mk("cyc_no_we", 0, 0,    1, 0, 5,    32'hAAAAAAAA, 4'hF, 0, 0);
    vecs[18] = mk("rd5_final", 1, 5,    0, 0, 0,    0,            4'h0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ack_a",  32'(ack_a),  32'(0));
    chk("reset.ack_b",  32'(ack_b),  32'(0));
    chk("reset.wack_a", 32'(wack_a), 32'(0));
    chk("reset.rdt_a",  rdt_a, 32'h0);
    chk("reset.rdt_b",  rdt_b, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < NV; i++) apply_vec(vecs[i]);

    // Streaming: preload 0..7 back-to-back, then 8 consecutive reads.
    @(posedge clk); #1;
    s1_cyc = 1'b1; s1_we = 1'b1; s1_sel = 4'hF;
    for (int k = 0; k < 8; k++) begin
      s1_adr = 10'(k); s1_dat = 32'(k);
      @(posedge clk); #1;
    end
    s1_cyc = 1'b0; s1_we = 1'b0;
    s0_cyc = 1'b1; s0_adr = 10'd0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k < 8) s0_adr = 10'(k);
      else       s0_cyc = 1'b0;
      @(negedge clk);
      chk($sformatf("stream%0d.ack_a", k), 32'(ack_a), 32'(k <= 8));
      chk($sformatf("stream%0d.rdt_a", k), rdt_a, (k <= 8) ? 32'(k - 1) : 32'd7);
      chk($sformatf("stream%0d.ack_b", k), 32'(ack_b), 32'(k >= 2));
      if (k >= 2) chk($sformatf("stream%0d.rdt_b", k), rdt_b, 32'(k - 2));
    end

    // Mid-flight reset: the latency-2 read must never ack; the write issued
    // during reset must neither ack nor land.
    @(posedge clk); #1;
    s0_cyc = 1'b1; s0_adr = 10'd10;
    @(posedge clk); #1;
    s0_cyc = 1'b0; reset = 1'b1;
    s1_cyc = 1'b1; s1_we = 1'b1; s1_adr = 10'd10; s1_dat = 32'hCAFEF00D; s1_sel = 4'hF;
    @(posedge clk); #1;
    s1_cyc = 1'b0; s1_we = 1'b0;
    @(negedge clk);
    chk("midrst.ack_b",  32'(ack_b),  32'(0));
    chk("midrst.wack_a", 32'(wack_a), 32'(0));
    chk("midrst.wack_b", 32'(wack_b), 32'(0));
    chk("midrst.rdt_a",  rdt_a, 32'h0);
    chk("midrst.rdt_b",  rdt_b, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d.ack_a", k), 32'(ack_a), 32'(0));
      chk($sformatf("postrst%0d.ack_b", k), 32'(ack_b), 32'(0));
      chk($sformatf("postrst%0d.rdt_b", k), rdt_b, 32'h0);
    end
    apply_vec(mk("rd10_after_rst", 1, 10, 0, 0, 0, 0, 4'h0, 32'h12345678, 32'h12345678));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
